// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester A/B command/response signals and ram control strobes
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_rd_req, ram_wr_req, ram_rd_valid, busy;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_rd_valid,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, ram_address, ram_rd_req, ram_wr_req, busy
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_rd_valid,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, ram_address, ram_rd_req, ram_wr_req, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer for a single-port ram on a shared data bus; define ARB_FIXED_PRIO_EN for fixed A-over-B priority
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      bus,
  inout  wire  [DATA_W-1:0] ram_data
);
  typedef enum logic [1:0] {IDLE, WR, RD, RD_RSP} state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] wdata_q, wdata_n, a_rdata_n, b_rdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic              own_b, own_b_n, ea, eb, pick_b, go, we_sel, a_rv_n, b_rv_n;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_b, last_b_n;
`endif
  assign ram_data = state == WR ? wdata_q : {DATA_W{1'bz}};
  assign bus.busy = state != IDLE;
  // arbitration, next state and next registered outputs; writes wait while the ram still drives the bus
  always_comb begin
    ea = state != RD && bus.a_req && !bus.a_gnt && !(bus.a_we && bus.ram_rd_valid);
    eb = state != RD && bus.b_req && !bus.b_gnt && !(bus.b_we && bus.ram_rd_valid);
`ifdef ARB_FIXED_PRIO_EN
    pick_b = eb && !ea;
`else
    pick_b = eb && (!ea || !last_b);
`endif
    go = ea || eb;
`ifndef ARB_FIXED_PRIO_EN
    last_b_n = go ? pick_b : last_b;
`endif
    we_sel = pick_b ? bus.b_we : bus.a_we;
    addr_n = go ? (pick_b ? bus.b_addr : bus.a_addr) : bus.ram_address;
    wdata_n = go && we_sel ? (pick_b ? bus.b_wdata : bus.a_wdata) : wdata_q;
    own_b_n = go ? pick_b : own_b;
    state_n = state == RD ? RD_RSP : !go ? IDLE : we_sel ? WR : RD;
    a_rv_n = state == RD_RSP && !own_b;
    b_rv_n = state == RD_RSP && own_b;
    a_rdata_n = a_rv_n ? ram_data : bus.a_rdata;
    b_rdata_n = b_rv_n ? ram_data : bus.b_rdata;
  end
  // state and output registers; an in-flight read is dropped on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      wdata_q         <= '0;
      own_b           <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_b          <= 1'b1;
`endif
      bus.a_gnt       <= 1'b0;
      bus.b_gnt       <= 1'b0;
      bus.a_rvalid    <= 1'b0;
      bus.b_rvalid    <= 1'b0;
      bus.a_rdata     <= '0;
      bus.b_rdata     <= '0;
      bus.ram_address <= '0;
      bus.ram_rd_req  <= 1'b0;
      bus.ram_wr_req  <= 1'b0;
    end else begin
      state           <= state_n;
      wdata_q         <= wdata_n;
      own_b           <= own_b_n;
`ifndef ARB_FIXED_PRIO_EN
      last_b          <= last_b_n;
`endif
      bus.a_gnt       <= go && !pick_b;
      bus.b_gnt       <= pick_b;
      bus.a_rvalid    <= a_rv_n;
      bus.b_rvalid    <= b_rv_n;
      bus.a_rdata     <= a_rdata_n;
      bus.b_rdata     <= b_rdata_n;
      bus.ram_address <= addr_n;
      bus.ram_rd_req  <= go && !we_sel;
      bus.ram_wr_req  <= go && we_sel;
    end
endmodule
